// File: rtl/spi_txn_ctrl_if.sv
// Bus bundle for the SPI transaction controller: two requester ports,
// the response port, status flags and the shifter handshake.
// slave  = the controller's view, master = the surrounding environment.
interface spi_txn_ctrl_if #(
    parameter int W_Data = 32
);
    // requester 0 (CPU)
    logic              req0_valid;
    logic [W_Data-1:0] req0_data;
    logic              req0_last;
    logic              req0_ready;
    // requester 1 (boot/DMA)
    logic              req1_valid;
    logic [W_Data-1:0] req1_data;
    logic              req1_last;
    logic              req1_ready;
    // response and status
    logic [W_Data-1:0] rsp_data;
    logic              rsp_valid;
    logic              rsp_id;
    logic              busy;
    logic              timeout_err;
    logic              ss_n;
    // shifter handshake
    logic [W_Data-1:0] shf_tx_data;
    logic              shf_tx_valid;
    logic              shf_tx_ready;
    logic [W_Data-1:0] shf_rx_data;
    logic              shf_rx_valid;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output rsp_data, rsp_valid, rsp_id, busy, timeout_err, ss_n,
        output shf_tx_data, shf_tx_valid,
        input  shf_tx_ready, shf_rx_data, shf_rx_valid
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  rsp_data, rsp_valid, rsp_id, busy, timeout_err, ss_n,
        input  shf_tx_data, shf_tx_valid,
        output shf_tx_ready, shf_rx_data, shf_rx_valid
    );
endinterface

// File: rtl/spi_txn_ctrl.sv
// SPI transaction controller: round-robin arbitration between two requesters,
// slave-select framing with setup/hold, word-by-word shifter sequencing and
// stall detection with a clean flush of the remaining words.
module spi_txn_ctrl #(
    parameter int W_Data   = 32,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic          clk,
    input  logic          rst,
    spi_txn_ctrl_if.slave bus
);

    // one shared counter covers setup, hold and the stall timeout
    localparam int CNT_MAX_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_MAX   = (TIMEOUT > CNT_MAX_A) ? TIMEOUT : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_END   = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SETUP,
        S_SEND,
        S_RECV,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              owner_reg;
    logic              last_grant_reg;
    logic              grant_sel;
    logic              last_reg;
    logic [W_Data-1:0] tx_data_reg;
    logic              tx_valid_reg;
    logic [W_Data-1:0] rsp_data_reg;
    logic              rsp_valid_reg;
    logic              rsp_id_reg;
    logic              timeout_reg;
    logic              ss_n_reg, ss_n_next;

    logic              take_tx;
    logic              take_flush;
    logic              take_rx;
    logic              timeout_hit;
    logic              take_word;

    // requester ports gathered into vectors so the owner can index them
    logic [1:0]        req_valid;
    logic [1:0]        req_last;
    logic [1:0]        req_ready;
    logic [W_Data-1:0] req_data [2];
    logic              own_valid;
    logic              own_last;
    logic [W_Data-1:0] own_data;

    assign req_valid   = {bus.req1_valid, bus.req0_valid};
    assign req_last    = {bus.req1_last,  bus.req0_last};
    assign req_data[0] = bus.req0_data;
    assign req_data[1] = bus.req1_data;

    assign own_valid = req_valid[owner_reg];
    assign own_last  = req_last[owner_reg];
    assign own_data  = req_data[owner_reg];

    // a word is consumed either by the shifter path or by the flush path
    assign take_word = take_tx | take_flush;

    // only the owner ever sees ready, so both can never be high together
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = take_word && (owner_reg == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready   = req_ready[0];
    assign bus.req1_ready   = req_ready[1];
    assign bus.rsp_data     = rsp_data_reg;
    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_id       = rsp_id_reg;
    assign bus.busy         = (state_reg != S_IDLE);
    assign bus.timeout_err  = timeout_reg;
    assign bus.ss_n         = ss_n_reg;
    assign bus.shf_tx_data  = tx_data_reg;
    assign bus.shf_tx_valid = tx_valid_reg;

    // next-state, handshake strobes, shared counter and slave-select target
    always_comb begin
        state_next  = state_reg;
        grant_sel   = last_grant_reg;
        take_tx     = 1'b0;
        take_flush  = 1'b0;
        take_rx     = 1'b0;
        timeout_hit = 1'b0;
        cnt_next    = '0;
        ss_n_next   = 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (|req_valid) begin
                    state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                // a tie goes to whichever requester was not granted last time
                if (req_valid == 2'b11) begin
                    grant_sel = ~last_grant_reg;
                end else begin
                    grant_sel = req_valid[1];
                end
                state_next = (|req_valid) ? S_SETUP : S_IDLE;
            end
            S_SETUP: begin
                if (cnt_reg == SETUP_END) begin
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (own_valid && bus.shf_tx_ready) begin
                    take_tx    = 1'b1;
                    state_next = S_RECV;
                end else if (cnt_reg == TIMEOUT_END) begin
                    // the stored last here belongs to an earlier, non-final word
                    timeout_hit = 1'b1;
                    state_next  = S_FLUSH;
                end
            end
            S_RECV: begin
                if (bus.shf_rx_valid) begin
                    take_rx    = 1'b1;
                    state_next = last_reg ? S_HOLD : S_SEND;
                end else if (cnt_reg == TIMEOUT_END) begin
                    timeout_hit = 1'b1;
                    state_next  = last_reg ? S_HOLD : S_FLUSH;
                end
            end
            S_HOLD: begin
                if (cnt_reg == HOLD_END) begin
                    state_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (own_valid) begin
                    take_flush = 1'b1;
                    if (own_last) begin
                        state_next = S_HOLD;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // counter restarts on every state change and runs only where it is compared
        if (state_next == state_reg &&
            (state_reg == S_SETUP || state_reg == S_SEND ||
             state_reg == S_RECV  || state_reg == S_HOLD)) begin
            cnt_next = cnt_reg + 1'b1;
        end

        // slave select is low for the whole framed part of a transaction
        ss_n_next = (state_next == S_IDLE) || (state_next == S_GRANT);
    end

    // state, counter, arbitration and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            last_reg       <= 1'b0;
            tx_data_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
            ss_n_reg       <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ss_n_reg      <= ss_n_next;
            tx_valid_reg  <= take_tx;
            rsp_valid_reg <= take_rx;
            timeout_reg   <= timeout_hit;

            if (state_reg == S_GRANT) begin
                owner_reg      <= grant_sel;
                last_grant_reg <= grant_sel;
                last_reg       <= 1'b0;
            end

            if (take_tx) begin
                tx_data_reg <= own_data;
                last_reg    <= own_last;
            end

            if (take_rx) begin
                rsp_data_reg <= bus.shf_rx_data;
                rsp_id_reg   <= owner_reg;
            end
        end
    end

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Directed bench for spi_txn_ctrl: bench-side shifter model (inverting echo),
// scoreboard queues for shifter words and responses, cycle-stamped event monitor.
module tb_spi_txn_ctrl;

    localparam int W         = 32;
    localparam int SHF_DELAY = 8;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;

    logic         r0_valid, r0_last, r1_valid, r1_last;
    logic [W-1:0] r0_data, r1_data;
    logic         s_ready, s_rx_valid;
    logic [W-1:0] s_rx_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    rsp_t         exp_rsp[$];
    logic [W-1:0] exp_tx[$];

    int tx_seen  = 0;
    int stall_at = 0;

    int n_tx = 0, last_tx_cyc = -1;
    int n_rsp = 0, last_rsp_cyc = -1;
    logic [W-1:0] last_rsp_data = '0;
    int n_to = 0, last_to_cyc = -1;
    int n_fall = 0, last_fall = -1, last_rise = -1, last_gap = -1;
    int rise_q[$];

    spi_txn_ctrl_if #(.W_Data(W)) bus ();

    assign bus.req0_valid   = r0_valid;
    assign bus.req0_data    = r0_data;
    assign bus.req0_last    = r0_last;
    assign bus.req1_valid   = r1_valid;
    assign bus.req1_data    = r1_data;
    assign bus.req1_last    = r1_last;
    assign bus.shf_tx_ready = s_ready;
    assign bus.shf_rx_valid = s_rx_valid;
    assign bus.shf_rx_data  = s_rx_data;

    spi_txn_ctrl #(
        .W_Data  (W),
        .CS_SETUP(2),
        .CS_HOLD (2),
        .TIMEOUT (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle_loop();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // shifter: answers each loaded word with its inverse SHF_DELAY cycles later
    task automatic shifter_loop();
        int cnt = 0;
        logic [W-1:0] resp = '0;
        forever begin
            @(negedge clk);
            s_rx_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    s_rx_valid = 1'b1;
                    s_rx_data  = resp;
                    s_ready    = 1'b1;
                end
            end
            if (bus.shf_tx_valid === 1'b1) begin
                tx_seen++;
                if (tx_seen != stall_at) begin
                    s_ready = 1'b0;
                    cnt     = SHF_DELAY;
                    resp    = ~bus.shf_tx_data;
                end
            end
        end
    endtask

    // monitor: scoreboard pops, event time stamps, ready exclusivity
    task automatic monitor_loop();
        logic prev_ss = 1'b1;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.shf_tx_valid === 1'b1) begin
                n_tx++;
                last_tx_cyc = cyc;
                chk("tx_expected", 32'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) chk("tx_data", bus.shf_tx_data, exp_tx.pop_front());
            end
            if (bus.rsp_valid === 1'b1) begin
                n_rsp++;
                last_rsp_cyc  = cyc;
                last_rsp_data = bus.rsp_data;
                chk("rsp_expected", 32'(exp_rsp.size() > 0), 1);
                if (exp_rsp.size() > 0) begin
                    e = exp_rsp.pop_front();
                    $display("rsp cyc=%0d id=%0d data=0x%08h", cyc, bus.rsp_id, bus.rsp_data);
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                end
            end
            if (bus.timeout_err === 1'b1) begin
                n_to++;
                last_to_cyc = cyc;
            end
            if (!$isunknown(bus.ss_n) && bus.ss_n !== prev_ss) begin
                if (bus.ss_n == 1'b0) begin
                    n_fall++;
                    last_gap  = cyc - last_rise;
                    last_fall = cyc;
                end else begin
                    last_rise = cyc;
                    rise_q.push_back(cyc);
                end
                prev_ss = bus.ss_n;
            end
            #1;
            chk("ready_excl", 32'(bus.req0_ready & bus.req1_ready), 0);
        end
    endtask

    task automatic drive(input int id, input logic v, input logic [W-1:0] d, input logic l);
        if (id == 0) begin
            r0_valid = v; r0_data = d; r0_last = l;
        end else begin
            r1_valid = v; r1_data = d; r1_last = l;
        end
    endtask

    // present one word; acc returns the cycle in which ready was seen
    task automatic send_word(input int id, input logic [W-1:0] d, input logic l, output int acc);
        logic rdy = 1'b0;
        int   c;
        acc = -1;
        drive(id, 1'b1, d, l);
        for (int n = 0; n < 300; n++) begin
            #1;
            rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
            c   = cyc;
            @(negedge clk);
            if (rdy === 1'b1) begin
                acc = c;
                break;
            end
        end
        drive(id, 1'b0, d, 1'b0);
        if (acc < 0) chk("accept_wait", 32'(rdy), 1);
        $display("req%0d word=0x%08h last=%0d accepted cyc=%0d", id, d, l, acc);
    endtask

    task automatic send_txn(input int id, input logic [W-1:0] first, input logic [W-1:0] step,
                            input int n, output int acc_first, output int acc_last);
        int a;
        acc_first = -1;
        acc_last  = -1;
        for (int k = 0; k < n; k++) begin
            send_word(id, first + 32'(k) * step, (k == n - 1), a);
            if (k == 0) acc_first = a;
            acc_last = a;
        end
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] first, input logic [W-1:0] step,
                            input int ntx, input int nrsp);
        rsp_t e;
        for (int k = 0; k < ntx; k++) exp_tx.push_back(first + 32'(k) * step);
        for (int k = 0; k < nrsp; k++) begin
            e.id   = 1'(id);
            e.data = ~(first + 32'(k) * step);
            exp_rsp.push_back(e);
        end
    endtask

    task automatic wait_idle(input string tag);
        logic done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (bus.busy === 1'b0 && bus.ss_n === 1'b1 && exp_rsp.size() == 0 && exp_tx.size() == 0)
                done = 1'b1;
        end
        chk(tag, 32'(done), 1);
        @(negedge clk);
    endtask

    initial begin
        int t, af, al, a0f, a0l, a1f, a1l, k, base, rise_v;
        r0_valid = 0; r0_last = 0; r0_data = '0;
        r1_valid = 0; r1_last = 0; r1_data = '0;
        s_ready = 1'b1; s_rx_valid = 1'b0; s_rx_data = '0;
        rst = 1'b0;
        fork
            cycle_loop();
            shifter_loop();
            monitor_loop();
        join_none

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_ss_n", 32'(bus.ss_n), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_tx_valid", 32'(bus.shf_tx_valid), 0);
        chk("rst_timeout", 32'(bus.timeout_err), 0);
        chk("rst_ready0", 32'(bus.req0_ready), 0);
        chk("rst_ready1", 32'(bus.req1_ready), 0);
        rst = 1'b1;
        @(negedge clk);

        // single word from req0, latency of every framing event
        t = cyc;
        push_exp(0, 32'hA5A5A5A5, 0, 1, 1);
        send_txn(0, 32'hA5A5A5A5, 0, 1, af, al);
        wait_idle("t1_idle");
        chk("t1_ss_fall", last_fall, t + 2);
        chk("t1_ready", af, t + 4);
        chk("t1_tx_valid", last_tx_cyc, t + 5);
        chk("t1_rsp_cyc", last_rsp_cyc, t + 14);
        chk("t1_rsp_data", last_rsp_data, 32'h5A5A5A5A);
        chk("t1_ss_rise", last_rise, last_rsp_cyc + 2);

        // simultaneous requests straight after reset: req0 first, then req1
        rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
        push_exp(0, 32'h100, 0, 1, 1);
        push_exp(1, 32'h200, 0, 1, 1);
        fork
            send_txn(0, 32'h100, 0, 1, a0f, a0l);
            send_txn(1, 32'h200, 0, 1, a1f, a1l);
        join
        wait_idle("t2_idle_a");
        chk("t2_req0_first", 32'(a1f > a0f), 1);
        chk("t2_ss_gap", last_gap, 2);
        // after req0 was granted alone, a tie goes to req1
        push_exp(0, 32'h300, 0, 1, 1);
        send_txn(0, 32'h300, 0, 1, af, al);
        wait_idle("t2_idle_b");
        push_exp(1, 32'h500, 0, 1, 1);
        push_exp(0, 32'h400, 0, 1, 1);
        fork
            send_txn(0, 32'h400, 0, 1, a0f, a0l);
            send_txn(1, 32'h500, 0, 1, a1f, a1l);
        join
        wait_idle("t2_idle_c");
        chk("t2_req1_wins", 32'(a0f > a1f), 1);

        // three-word transaction under one slave-select frame
        base = n_fall; k = rise_q.size(); t = n_rsp;
        push_exp(1, 32'h1, 32'h1, 3, 3);
        send_txn(1, 32'h1, 32'h1, 3, af, al);
        wait_idle("t3_idle");
        chk("t3_ss_falls", n_fall - base, 1);
        chk("t3_ss_rises", rise_q.size() - k, 1);
        chk("t3_rsp_count", n_rsp - t, 3);

        // req1 arrives mid-transaction and must wait for req0 to finish
        k = rise_q.size();
        push_exp(0, 32'h40, 32'h1, 2, 2);
        push_exp(1, 32'h50, 0, 1, 1);
        fork
            send_txn(0, 32'h40, 32'h1, 2, a0f, a0l);
            begin
                repeat (6) @(negedge clk);
                send_txn(1, 32'h50, 0, 1, a1f, a1l);
            end
        join
        wait_idle("t4_idle");
        rise_v = (rise_q.size() > k) ? rise_q[k] : -100;
        chk("t4_req1_after_idle", a1f, rise_v + 4);

        // stalled shifter on word 1 of 3: timeout, flush, hold
        base = n_to; t = n_rsp;
        stall_at = tx_seen + 1;
        push_exp(0, 32'h11, 32'h11, 1, 0);
        send_txn(0, 32'h11, 32'h11, 3, af, al);
        wait_idle("t5_idle");
        chk("t5_timeout_count", n_to - base, 1);
        chk("t5_timeout_cycle", last_to_cyc - last_tx_cyc, 16);
        chk("t5_no_rsp", n_rsp - t, 0);
        chk("t5_ss_rise", last_rise, al + 3);

        // asynchronous reset while waiting in RECV
        push_exp(0, 32'h66, 0, 1, 0);
        send_txn(0, 32'h66, 0, 1, af, al);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_ss_n", 32'(bus.ss_n), 1);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("t6_tx_valid", 32'(bus.shf_tx_valid), 0);
        chk("t6_timeout", 32'(bus.timeout_err), 0);
        chk("t6_ready0", 32'(bus.req0_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        t = n_rsp;
        push_exp(0, 32'h77, 0, 1, 1);
        send_txn(0, 32'h77, 0, 1, af, al);
        wait_idle("t6_idle");
        chk("t6_rsp_count", n_rsp - t, 1);
        chk("t6_rsp_data", last_rsp_data, ~32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
